motor_phase_decoder: RTL and testbench

//  Monitors the four coil lines (P,M,L,Y) of the unipolar stepper drive. Decodes the phase

---
 rtl/motor_phase_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_motor_phase_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_phase_decoder.sv
// Purpose : observes the four unipolar stepper coil lines {P,M,L,Y}, rebuilds step
//           pulses, direction and a signed position count, and flags illegal or skipped phases.
// Latency : outputs update on edge SYNC_STAGES+1 after a pin change (+DEB_CYCLES with DEBOUNCE_EN).
// Backpressure: none; this is a passive observer and never stalls. Pins are sampled every cycle.
//
// Optional feature macro: DEBOUNCE_EN
//   defined   -> a new synchronized pattern must stay constant for DEB_CYCLES cycles
//                before it is evaluated; shorter pulses are dropped silently.
//   undefined -> every synchronized pattern is evaluated on the next edge; no counter exists.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   P,M,L,Y   in   coil drive lines, asynchronous to clock
//   clr_err   in   synchronous fault clear (level); only acts in the FAULT state
//   zero_pos  in   synchronous position clear (level); acts in every state
//   step      out  one-cycle pulse per accepted step
//   dir       out  direction of the last step, 1 = forward, 0 = reverse
//   pos       out  POS_W-bit two's complement step count, wraps modulo 2^POS_W
//   phase     out  last accepted phase index 0..3
//   locked    out  decoder is synchronized to a valid phase
//   err       out  sticky fault flag

module motor_phase_decoder #(
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             P,
    input  logic             M,
    input  logic             L,
    input  logic             Y,
    input  logic             clr_err,
    input  logic             zero_pos,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err
);

    // Elaboration-time sanity check: one sync flop is not a synchronizer, and a
    // zero-length debounce window would never evaluate anything.
    if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("motor_phase_decoder: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
    end

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    // Coil patterns {P,M,L,Y} for the four legal phases.
    localparam logic [3:0] PAT_PH0 = 4'b1001;
    localparam logic [3:0] PAT_PH1 = 4'b1010;
    localparam logic [3:0] PAT_PH2 = 4'b0110;
    localparam logic [3:0] PAT_PH3 = 4'b0101;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. All four lines travel together through the same
    // flop chain; a pattern caught mid-transition shows up as one transient
    // code, which is what the debounce option exists to filter.
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] spat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= {P, M, L, Y};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign spat = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Evaluation source: either the raw synchronized pattern or the
    // debounced copy of it. eval_vld qualifies eval_pat for the FSM.
    // ------------------------------------------------------------------
    logic [3:0] eval_pat;
    logic       eval_vld;

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       deb_pat;
    logic [CNT_W-1:0] deb_cnt;

    // deb_pat is a one-cycle-delayed copy of spat; deb_cnt counts how many
    // further cycles spat has matched it. A change restarts the count. Once
    // the count reaches DEB_CYCLES-1 the held pattern has been stable for
    // DEB_CYCLES cycles and stays eligible for as long as it remains stable
    // (saturating), so a pattern left in place after a fault clear still
    // gets evaluated in UNLOCKED.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_pat <= 4'b0000;
            deb_cnt <= '0;
        end else if (spat != deb_pat) begin
            deb_pat <= spat;
            deb_cnt <= '0;
        end else if (deb_cnt != CNT_LAST) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Evaluate the registered copy: on the edge where the window completes,
    // spat itself may already be moving on to the next pattern.
    assign eval_pat = deb_pat;
    assign eval_vld = (deb_cnt == CNT_LAST);
`else
    assign eval_pat = spat;
    assign eval_vld = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Pattern decode.
    // ------------------------------------------------------------------
    logic       pat_ok;
    logic [1:0] pat_idx;

    always_comb begin
        pat_ok  = 1'b1;
        pat_idx = 2'd0;
        case (eval_pat)
            PAT_PH0: pat_idx = 2'd0;
            PAT_PH1: pat_idx = 2'd1;
            PAT_PH2: pat_idx = 2'd2;
            PAT_PH3: pat_idx = 2'd3;
            default: pat_ok  = 1'b0;
        endcase
    end

    // Distance from the accepted phase to the new one, modulo 4:
    // 0 = same, 1 = forward neighbour, 3 = reverse neighbour, 2 = skipped step.
    logic [1:0] delta;
    assign delta = pat_idx - phase;

    // ------------------------------------------------------------------
    // FSM: state register plus all registered outputs.
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic             step_nxt;
    logic             dir_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic [1:0]       phase_nxt;
    logic             locked_nxt;
    logic             err_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_UNLOCKED;
            step   <= 1'b0;
            dir    <= 1'b0;
            pos    <= '0;
            phase  <= 2'd0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            dir    <= dir_nxt;
            pos    <= pos_nxt;
            phase  <= phase_nxt;
            locked <= locked_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = 1'b0;
        dir_nxt   = dir;
        pos_nxt   = pos;
        phase_nxt = phase;
        err_nxt   = err;

        case (state)
            ST_UNLOCKED: begin
                // Illegal codes are expected here (power-up, after a fault) and
                // are not errors; lock onto the first legal phase without counting.
                if (eval_vld && pat_ok) begin
                    phase_nxt = pat_idx;
                    state_nxt = ST_LOCKED;
                end
            end

            ST_LOCKED: begin
                if (eval_vld) begin
                    if (!pat_ok || delta == 2'd2) begin
                        // Illegal code or a skipped phase: direction is unknowable,
                        // so position and phase are frozen at the last good step.
                        err_nxt   = 1'b1;
                        state_nxt = ST_FAULT;
                    end else if (delta == 2'd1) begin
                        step_nxt  = 1'b1;
                        dir_nxt   = 1'b1;
                        pos_nxt   = pos + POS_ONE;
                        phase_nxt = pat_idx;
                    end else if (delta == 2'd3) begin
                        step_nxt  = 1'b1;
                        dir_nxt   = 1'b0;
                        pos_nxt   = pos - POS_ONE;
                        phase_nxt = pat_idx;
                    end
                end
            end

            ST_FAULT: begin
                // Inputs are ignored until software acknowledges the fault.
                if (clr_err) begin
                    err_nxt   = 1'b0;
                    state_nxt = ST_UNLOCKED;
                end
            end

            default: begin
                state_nxt = ST_UNLOCKED;
            end
        endcase

        // Position clear overrides any count on the same edge; step and dir
        // above are left as computed.
        if (zero_pos) begin
            pos_nxt = '0;
        end

        locked_nxt = (state_nxt == ST_LOCKED);
    end

endmodule

// File: tb/tb_motor_phase_decoder.sv
module tb_motor_phase_decoder;

    localparam int POS_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + 1 + DEB_CYCLES;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic             clock;
    logic             reset;
    logic             P, M, L, Y;
    logic             clr_err;
    logic             zero_pos;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic [1:0]       phase;
    logic             locked;
    logic             err;

    motor_phase_decoder #(
        .POS_W      (POS_W),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .P       (P),
        .M       (M),
        .L       (L),
        .Y       (Y),
        .clr_err (clr_err),
        .zero_pos(zero_pos),
        .step    (step),
        .dir     (dir),
        .pos     (pos),
        .phase   (phase),
        .locked  (locked),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        dir;
        logic [15:0] pos;
        logic [1:0]  phase;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] pats [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a pattern, then hold it for n rising edges; returns 2 time units after the last edge.
    task automatic apply(input logic [3:0] p, input int n);
        {P, M, L, Y} = p;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic expect_step(input logic d, input logic [15:0] ps, input logic [1:0] ph);
        exp_t e;
        e.dir   = d;
        e.pos   = ps;
        e.phase = ph;
        sb.push_back(e);
    endtask

    // Drive a pattern and count edges until the step pulse appears (bounded).
    task automatic measure(input logic [3:0] p, input string name);
        int lat;
        lat = 0;
        {P, M, L, Y} = p;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #3;
            if (step) begin
                lat = n;
                break;
            end
        end
        chk(name, lat, LAT);
    endtask

    // Monitor: every step pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset && step) begin
            if (sb.size() == 0) begin
                chk("unexpected_step", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("step_pulse", {13'd0, dir, pos, phase}, {13'd0, mon_e});
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        {P, M, L, Y} = 4'b0000;
        clr_err  = 1'b0;
        zero_pos = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        // Reset state
        chk("rst_step",   step,   0);
        chk("rst_dir",    dir,    0);
        chk("rst_pos",    pos,    0);
        chk("rst_phase",  phase,  0);
        chk("rst_locked", locked, 0);
        chk("rst_err",    err,    0);
        reset = 1'b1;
        apply(4'b0000, 2);
        chk("idle_illegal_no_err", err, 0);

        // T1: lock onto ph0 exactly LAT edges after the pin change, no step
        {P, M, L, Y} = 4'b1001;
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clock);
            #3;
            if (n == LAT - 1) chk("t1_not_locked_early", locked, 0);
        end
        chk("t1_locked", locked, 1);
        apply(4'b1001, 8);
        chk("t1_phase", phase, 0);
        chk("t1_pos",   pos,   0);

        // T2: four forward steps
        expect_step(1'b1, 16'd1, 2'd1);
        measure(4'b1010, "t2_latency");
        apply(4'b1010, 8);
        expect_step(1'b1, 16'd2, 2'd2); apply(4'b0110, 8);
        expect_step(1'b1, 16'd3, 2'd3); apply(4'b0101, 8);
        expect_step(1'b1, 16'd4, 2'd0); apply(4'b1001, 8);
        chk("t2_pos",   pos,   4);
        chk("t2_phase", phase, 0);
        chk("t2_dir",   dir,   1);

        // T3: clear, then two reverse steps through zero
        zero_pos = 1'b1;
        apply(4'b1001, 1);
        zero_pos = 1'b0;
        apply(4'b1001, 2);
        chk("t3_zero", pos, 0);
        expect_step(1'b0, 16'hFFFF, 2'd3); apply(4'b0101, 8);
        expect_step(1'b0, 16'hFFFE, 2'd2); apply(4'b0110, 8);
        chk("t3_pos",   pos,   16'hFFFE);
        chk("t3_dir",   dir,   0);
        chk("t3_phase", phase, 2);

        // T4: forward to ph1, then skip to ph3
        expect_step(1'b1, 16'hFFFF, 2'd3); apply(4'b0101, 8);
        expect_step(1'b1, 16'h0000, 2'd0); apply(4'b1001, 8);
        expect_step(1'b1, 16'h0001, 2'd1); apply(4'b1010, 8);
        apply(4'b0101, 8);
        chk("t4_skip_err",    err,    1);
        chk("t4_skip_locked", locked, 0);
        chk("t4_skip_pos",    pos,    1);
        chk("t4_skip_phase",  phase,  1);
        apply(4'b1001, 8);
        chk("t4_fault_ignores_err",   err,   1);
        chk("t4_fault_ignores_phase", phase, 1);
        apply(4'b0000, 4);
        clr_err = 1'b1;
        apply(4'b0000, 1);
        clr_err = 1'b0;
        apply(4'b0000, 4);
        chk("t4_clr_err",    err,    0);
        chk("t4_clr_locked", locked, 0);
        apply(4'b0101, 8);
        chk("t4_relock",       locked, 1);
        chk("t4_relock_phase", phase,  3);
        chk("t4_relock_pos",   pos,    1);
        // Illegal code while locked
        apply(4'b1111, 8);
        chk("t4_illegal_err",   err,   1);
        chk("t4_illegal_phase", phase, 3);
        clr_err = 1'b1;
        apply(4'b1111, 1);
        clr_err = 1'b0;
        apply(4'b1111, 4);
        chk("t4_clr2_err",    err,    0);
        chk("t4_clr2_locked", locked, 0);
        apply(4'b0101, 8);
        chk("t4_relock2", locked, 1);

`ifdef DEBOUNCE_EN
        // T6: short glitch is dropped; held neighbour steps after the debounce window
        apply(4'b0000, 2);
        apply(4'b0101, 10);
        chk("t6_glitch_err",    err,    0);
        chk("t6_glitch_locked", locked, 1);
        expect_step(1'b1, 16'd2, 2'd0);
        measure(4'b1001, "t6_latency");
        apply(4'b1001, 8);
        chk("t6_pos", pos, 2);
`else
        // T5: wrap 0x7FFF -> 0x8000 with one-cycle patterns, then zero on a step edge
        zero_pos = 1'b1;
        apply(4'b0101, 1);
        zero_pos = 1'b0;
        apply(4'b0101, 2);
        chk("t5_zero", pos, 0);
        for (int i = 1; i <= 32768; i++) begin
            logic [1:0] ph;
            ph = 2'((3 + i) % 4);
            expect_step(1'b1, i[15:0], ph);
            apply(pats[ph], 1);
        end
        apply(4'b0101, 8);
        chk("t5_wrap_pos", pos, 16'h8000);
        expect_step(1'b1, 16'h0000, 2'd0);
        apply(4'b1001, 2);
        zero_pos = 1'b1;
        apply(4'b1001, 1);
        zero_pos = 1'b0;
        apply(4'b1001, 8);
        chk("t5_zero_step_pos",   pos,   0);
        chk("t5_zero_step_phase", phase, 0);
`endif

        repeat (5) @(posedge clock);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
